console_mux: RTL and testbench
==============================

CONSOLE_MUX -- requirements
Module: console_mux

Interface
REQ-001 Parameter W, default 8, character width in bits.
REQ-002 Parameter NCH, default 2, number of strobed console channels (1..8).
REQ-003 Parameter DEPTH, default 16, output FIFO depth in entries (power of two, at least 2).
REQ-004 phi  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 strobe  input  NCH  per-channel character strobe, sampled on each rising phi.
REQ-007 cin  input  NCH*W  per-channel character data; channel i occupies bits [i*W +: W].
REQ-008 out_valid  output  1  FIFO head valid.
REQ-009 out_ready  input  1  consumer accepts the head.
REQ-010 out_data  output  W  character at the FIFO head.
REQ-011 out_chan  output  max(1,clog2(NCH))  source channel of the head.
REQ-012 overflow  output  NCH  sticky per-channel drop flags.
REQ-013 level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 Each channel SHALL own a one-entry holding register plus a pend bit.
REQ-015 Strobe high at an edge with pend clear SHALL load the holding register from cin and set pend.
REQ-016 If pend is set and the channel is granted at the same edge, a strobe SHALL load the new character, keep pend set, and drop nothing.
REQ-017 If pend is set and the channel is not granted, a strobe SHALL discard the character, leave the held character unchanged, and set overflow[i].
REQ-018 The round-robin arbiter SHALL grant at most one pending channel per edge, and only when level < DEPTH before that edge.
REQ-019 The grant SHALL go to the first pending channel at or after the priority pointer, wrapping modulo NCH.
REQ-020 After a grant to channel g, the priority pointer SHALL become (g+1) mod NCH; with no grant it SHALL hold.
REQ-021 A grant SHALL push {g, held character} into the FIFO and clear pend[g], except as given in REQ-016.
REQ-022 Latency: strobe sampled at edge t, with the channel alone and the FIFO empty, SHALL give out_valid=1 after edge t+1.
REQ-023 out_valid SHALL equal (level != 0); out_data and out_chan SHALL show the head combinationally from registered storage.
REQ-024 A pop SHALL occur when out_valid and out_ready are both high; out_data and out_chan SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous push and pop SHALL leave level unchanged. Full is judged on pre-edge level, so a pop does not enable a push at the same edge.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.
REQ-027 overflow bits SHALL clear only on rst.

Reset
REQ-028 rst high at an edge SHALL clear pend, holding registers, FIFO pointers, level, priority pointer (to 0) and overflow, overriding any strobe or pop at the same edge.
REQ-029 Immediately after reset: out_valid=0, level=0, overflow=0, out_data=0, out_chan=0.
REQ-030 A reset mid-stream SHALL discard all buffered characters with no partial output.

Structure
REQ-031 A shared package SHALL hold the default W, NCH and DEPTH constants and the FIFO entry struct type {chan, data}.
REQ-032 The FIFO SHALL be one sub-module, console_fifo, parameterised by entry width and DEPTH, with push/pop/level ports. Arbiter and holding registers SHALL stay in console_mux.

Verification
REQ-033 Single char: NCH=2; strobe0 with cin0=0x41 for one edge, out_ready=1 -> one beat, out_data=0x41, out_chan=0, after edge t+1; level returns to 0.
REQ-034 Round robin: both strobes at one edge (0x61 on ch0, 0x62 on ch1), pointer=0 -> output order (0,0x61) then (1,0x62). Repeat from pointer=1 -> ch1 first.
REQ-035 Overflow: strobe ch1 with 0x10 then 0x11 on consecutive edges while ch0 is continuously pending and wins the grant -> 0x11 dropped, overflow=2'b10, 0x10 delivered.
REQ-036 Full/backpressure: DEPTH=4, out_ready=0, six single-channel strobes spaced 2 edges apart -> level saturates at 4, overflow[0]=1, out_data stable; then raise out_ready -> first 4 characters emerge in order.
REQ-037 Simultaneous push/pop at level=2 -> level stays 2; data order preserved across pointer wrap (write 20 chars through DEPTH=4).
REQ-038 Reset mid-operation: level=3, overflow set, rst for one edge with strobe high -> all outputs per REQ-029, strobed character not captured.

Source files
------------

// File: rtl/console_mux_pkg.sv
// rtl/console_mux_pkg.sv - shared defaults, fifo entry type and width helper for console_mux
package console_mux_pkg;

    localparam int W_DEF     = 8;
    localparam int NCH_DEF   = 2;
    localparam int DEPTH_DEF = 16;

    // Channel index width; a single channel still needs one bit.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CHW_DEF = chan_width(NCH_DEF);

    typedef struct packed {
        logic [CHW_DEF-1:0] chan;
        logic [W_DEF-1:0]   data;
    } console_entry_t;

endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - output fifo holding {chan, data} entries with occupancy count
module console_fifo #(
    parameter int EW    = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          phi,
    input  logic          rst,
    input  logic          push,
    input  logic [EW-1:0] push_data,
    input  logic          pop,
    output logic [EW-1:0] pop_data,
    output logic [LW-1:0] level
);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full and empty are judged on the pre-edge level, so a pop never frees
    // room for a push in the same cycle.
    assign do_push = push && (level != LW'(DEPTH)) && !rst;
    assign do_pop  = pop && (level != '0) && !rst;

    // Storage is not reset; the head reads as zero whenever the fifo is empty.
    assign pop_data = (level != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge phi) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge phi) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/console_mux.sv
// rtl/console_mux.sv - round-robin merge of strobed console channels into one output fifo
module console_mux
    import console_mux_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int NCH   = NCH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW   = chan_width(NCH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             phi,
    input  logic             rst,
    input  logic [NCH-1:0]   strobe,
    input  logic [NCH*W-1:0] cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_chan,
    output logic [NCH-1:0]   overflow,
    output logic [LW-1:0]    level
);

    logic [W-1:0]    hold [NCH];
    logic [NCH-1:0]  pend;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   cand;
    logic [CW-1:0]   grant_idx;
    logic            grant_valid;
    logic [CW+W-1:0] push_data;
    logic [CW+W-1:0] head;

    // Scan from the farthest candidate back to the pointer so the last hit,
    // i.e. the first pending channel at or after ptr, wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = CW'((int'(ptr) + k) % NCH);
            if (pend[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (level == LW'(DEPTH)) begin
            grant_valid = 1'b0;
        end
    end

    assign push_data = {grant_idx, hold[grant_idx]};

    always_ff @(posedge phi) begin
        if (rst) begin
            pend     <= '0;
            ptr      <= '0;
            overflow <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (strobe[i]) begin
                    // A granted channel frees its register this edge, so it can
                    // take the new character without a drop.
                    if (!pend[i] || (grant_valid && grant_idx == CW'(i))) begin
                        hold[i] <= cin[i*W +: W];
                        pend[i] <= 1'b1;
                    end else begin
                        overflow[i] <= 1'b1;
                    end
                end else if (grant_valid && grant_idx == CW'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
            if (grant_valid) begin
                ptr <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    console_fifo #(
        .EW    (CW + W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .phi       (phi),
        .rst       (rst),
        .push      (grant_valid),
        .push_data (push_data),
        .pop       (out_valid && out_ready),
        .pop_data  (head),
        .level     (level)
    );

    assign out_valid = (level != '0);
    assign out_chan  = head[CW+W-1:W];
    assign out_data  = head[W-1:0];

endmodule

// File: tb/tb_console_mux.sv
// tb/tb_console_mux.sv - scoreboard bench for console_mux with two channels and a four-deep fifo
module tb_console_mux;
    import console_mux_pkg::*;

    logic        phi = 1'b0;
    logic        rst;
    logic [1:0]  strobe;
    logic [15:0] cin;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [0:0]  out_chan;
    logic [1:0]  overflow;
    logic [2:0]  level;

    int checks   = 0;
    int failures = 0;

    console_entry_t sb[$];

    console_mux #(
        .W     (8),
        .NCH   (2),
        .DEPTH (4)
    ) dut (
        .phi       (phi),
        .rst       (rst),
        .strobe    (strobe),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 phi = ~phi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic console_entry_t ent(input logic ch, input int d);
        console_entry_t e;
        e.chan = ch;
        e.data = 8'(d);
        return e;
    endfunction

    // Captures the head just before the edge; a beat consumed at that edge
    // is compared against the oldest expected entry.
    task automatic step();
        logic           p;
        console_entry_t e;
        p = out_valid && out_ready && !rst;
        e = {out_chan, out_data};
        @(posedge phi);
        #1;
        if (p) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                check("pop_beat", 32'(e), 32'(sb.pop_front()));
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        strobe = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_chan"}, 32'(out_chan), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        strobe    = '0;
        cin       = '0;
        out_ready = 1'b0;
        #1;

        do_reset();
        check_reset_outputs("rst0");

        // Single character and latency.
        out_ready = 1'b1;
        strobe = 2'b01;
        cin    = {8'h00, 8'h41};
        sb.push_back(ent(1'b0, 'h41));
        step();
        strobe = '0;
        check("lat_t_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_t1_valid", 32'(out_valid), 32'd1);
        check("lat_t1_level", 32'(level), 32'd1);
        check("lat_t1_data", 32'(out_data), 32'h41);
        check("lat_t1_chan", 32'(out_chan), 32'd0);
        step();
        check_drained("single");

        // Round robin from pointer 0, then from pointer 1.
        do_reset();
        out_ready = 1'b1;
        strobe = 2'b11;
        cin    = {8'h62, 8'h61};
        sb.push_back(ent(1'b0, 'h61));
        sb.push_back(ent(1'b1, 'h62));
        step();
        strobe = '0;
        repeat (4) step();
        strobe = 2'b01;
        cin    = {8'h00, 8'h30};
        sb.push_back(ent(1'b0, 'h30));
        step();
        strobe = '0;
        repeat (3) step();
        strobe = 2'b11;
        cin    = {8'h64, 8'h63};
        sb.push_back(ent(1'b1, 'h64));
        sb.push_back(ent(1'b0, 'h63));
        step();
        strobe = '0;
        repeat (4) step();
        check_drained("rr");

        // Overflow on ch1 while ch0 stays pending and wins.
        do_reset();
        out_ready = 1'b1;
        strobe = 2'b11;
        cin    = {8'h10, 8'hA0};
        sb.push_back(ent(1'b0, 'hA0));
        sb.push_back(ent(1'b1, 'h10));
        step();
        cin = {8'h11, 8'hA1};
        sb.push_back(ent(1'b0, 'hA1));
        step();
        strobe = '0;
        check("ovf_bits", 32'(overflow), 32'h2);
        repeat (5) step();
        check_drained("ovf");
        check("ovf_sticky", 32'(overflow), 32'h2);

        // Fill to full under backpressure.
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            strobe = 2'b01;
            cin    = {8'h00, 8'(8'h50 + n)};
            if (n < 5) sb.push_back(ent(1'b0, 'h50 + n));
            step();
            strobe = '0;
            step();
            check("full_level", 32'(level), 32'((n < 4) ? n + 1 : 4));
            check("full_head", 32'(out_data), 32'h50);
        end
        check("full_ovf", 32'(overflow), 32'h1);
        out_ready = 1'b1;
        repeat (8) step();
        check_drained("full");

        // Steady push+pop at level 2 across pointer wrap.
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            strobe = 2'b01;
            cin    = {8'h00, 8'(8'h70 + n)};
            sb.push_back(ent(1'b0, 'h70 + n));
            step();
            strobe = '0;
            step();
        end
        check("wrap_pre_level", 32'(level), 32'd2);
        strobe = 2'b01;
        cin    = {8'h00, 8'h72};
        sb.push_back(ent(1'b0, 'h72));
        step();
        check("wrap_held_level", 32'(level), 32'd2);
        out_ready = 1'b1;
        for (int k = 3; k < 20; k++) begin
            strobe = 2'b01;
            cin    = {8'h00, 8'(8'h70 + k)};
            sb.push_back(ent(1'b0, 'h70 + k));
            step();
            check("wrap_level", 32'(level), 32'd2);
        end
        strobe = '0;
        step();
        check("wrap_last_level", 32'(level), 32'd2);
        repeat (4) step();
        check_drained("wrap");

        // Reset in the middle of traffic.
        do_reset();
        out_ready = 1'b0;
        strobe = 2'b11;
        cin    = {8'h91, 8'h90};
        step();
        strobe = 2'b10;
        cin    = {8'h92, 8'h00};
        step();
        strobe = '0;
        step();
        strobe = 2'b01;
        cin    = {8'h00, 8'h93};
        step();
        strobe = '0;
        step();
        check("mid_level", 32'(level), 32'd3);
        check("mid_ovf", 32'(overflow), 32'h2);
        rst    = 1'b1;
        strobe = 2'b01;
        cin    = {8'h00, 8'hEE};
        step();
        rst    = 1'b0;
        strobe = '0;
        check_reset_outputs("mid_rst");
        step();
        step();
        check("mid_no_capture_valid", 32'(out_valid), 32'd0);
        check("mid_no_capture_level", 32'(level), 32'd0);
        check("end_sb_left", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
